vga_sprite_renderer: RTL

- Pipelined, parametrised pixel generator for the VGA output path.
- Sits between the tile-map lookup (which supplies the entity code of the cell under the beam) and the VGA DAC pins.
- Generalises the 1-bit, 3-sprite, two-mode drawer:
  - N-bit colour per channel, N sprites held in a runtime-writable sprite RAM
  - transparency key, four display modes
  - explicit blanking
  - fixed 2-cycle latency with a delayed data-enable.

---
 rtl/vga_sprite_renderer.sv | 99 +++++++++
 1 files changed

// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: two-stage pixel generator (sprite RAM, colour bars, fill, checker)
// with a transparency key, blanking and a 2-cycle delayed data-enable.
module vga_sprite_renderer #(
   parameter int COLOR_BITS     = 1,
   parameter int ENT_W          = 2,
   parameter int CELL_LOG2_W    = 4,
   parameter int CELL_LOG2_H    = 4,
   parameter int BAR_H          = 60,
   parameter bit TRANSPARENT_EN = 1'b1
) (
   input  logic                                      iVGA_CLK,
   input  logic                                      reset_n,
   input  logic [9:0]                                iVGA_X,
   input  logic [9:0]                                iVGA_Y,
   input  logic                                      iDE,
   input  logic [ENT_W-1:0]                          iEnt,
   input  logic [1:0]                                iMode,
   input  logic [3*COLOR_BITS-1:0]                   iBg,
   input  logic [3*COLOR_BITS-1:0]                   iKey,
   input  logic                                      iWr_en,
   input  logic [ENT_W+CELL_LOG2_W+CELL_LOG2_H-1:0]  iWr_addr,
   input  logic [3*COLOR_BITS-1:0]                   iWr_data,
   output logic                                      oWr_ready,
   output logic [COLOR_BITS-1:0]                     oRed,
   output logic [COLOR_BITS-1:0]                     oGreen,
   output logic [COLOR_BITS-1:0]                     oBlue,
   output logic                                      oDE
);
   localparam int CW = 3*COLOR_BITS;
   localparam int AW = ENT_W+CELL_LOG2_W+CELL_LOG2_H;

   logic [CW-1:0]    mem_q [2**AW];
   logic [CW-1:0]    rd_q, bg_q, key_q, rgb_q, spr_d, bar_d, pix_d;
   logic [ENT_W-1:0] ent_q;
   logic [1:0]       mode_q;
   logic [2:0]       bar_q, k_d;
   logic             de_q, de2_q, chk_q, chk_d, unused_x;
   logic [AW-1:0]    addr_d;

   assign oWr_ready = ~iDE;
   assign unused_x  = ^iVGA_X[9:CELL_LOG2_W+1];
   assign chk_d     = iVGA_X[CELL_LOG2_W] ^ iVGA_Y[CELL_LOG2_H];
   // Single port: reads own the address while iDE is high, writes only in blanking.
   assign addr_d    = iDE ? {iEnt, iVGA_Y[CELL_LOG2_H-1:0], iVGA_X[CELL_LOG2_W-1:0]} : iWr_addr;

   always_ff @(posedge iVGA_CLK) begin
      if (iWr_en && !iDE) mem_q[addr_d] <= iWr_data;
      if (iDE) rd_q <= mem_q[addr_d];
   end

   always_comb begin
      k_d = 3'd0;
      for (int i = 1; i < 8; i++) if (int'(iVGA_Y) >= i*BAR_H) k_d = 3'(i);
   end

   always_ff @(posedge iVGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= '0;
         ent_q  <= '0;
         de_q   <= 1'b0;
         bar_q  <= '0;
         chk_q  <= 1'b0;
         bg_q   <= '0;
         key_q  <= '0;
      end else begin
         mode_q <= iMode;
         ent_q  <= iEnt;
         de_q   <= iDE;
         bar_q  <= k_d;
         chk_q  <= chk_d;
         bg_q   <= iBg;
         key_q  <= iKey;
      end
   end

   always_comb begin
      spr_d = (ent_q == '0 || (TRANSPARENT_EN && rd_q == key_q)) ? bg_q : rd_q;
      bar_d = {{COLOR_BITS{~bar_q[2]}}, {COLOR_BITS{~bar_q[0]}}, {COLOR_BITS{~bar_q[1]}}};
      pix_d = mode_q == 2'd0 ? spr_d :
              mode_q == 2'd1 ? bar_d :
              mode_q == 2'd2 ? bg_q  :
              (chk_q ? bg_q : ~bg_q);
   end

   always_ff @(posedge iVGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q <= '0;
         de2_q <= 1'b0;
      end else begin
         rgb_q <= de_q ? pix_d : '0;
         de2_q <= de_q;
      end
   end

   assign oRed   = rgb_q[CW-1 -: COLOR_BITS];
   assign oGreen = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
   assign oBlue  = rgb_q[COLOR_BITS-1:0];
   assign oDE    = de2_q;
endmodule
